// File: rtl/interrupt_register.sv
// Eight-source interrupt pending register: each source is synchronised,
// rising-edge detected, and latches a sticky bit that the handler clears by index.
module interrupt_register (
    input  logic       CLK,
    input  logic       RST,
    input  logic       North_Button,
    input  logic       South_Button,
    input  logic       East_Button,
    input  logic       West_Button,
    input  logic       Sw3,
    input  logic       Sw2,
    input  logic       Sw1,
    input  logic       Sw0,
    input  logic [3:0] CLR,
    output logic [7:0] State
);

    logic [7:0] src;
    logic [7:0] s1_q;
    logic [7:0] s2_q;
    logic [7:0] prev_q;
    logic [7:0] state_q;
    logic [7:0] state_d;
    logic [7:0] rise;
    logic [7:0] clr_mask;

    assign src = {North_Button, South_Button, East_Button, West_Button,
                  Sw3, Sw2, Sw1, Sw0};

    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves a value unassigned (no latch).
    always_comb begin
        clr_mask = 8'h00;
        if (CLR[3]) begin
            clr_mask = 8'b1 << CLR[2:0];
        end
        rise    = s2_q & ~prev_q;
        // A set and a clear of the same bit in one cycle resolves to set.
        state_d = (state_q & ~clr_mask) | rise;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value
    // of its neighbour; this is what makes s1 -> s2 -> prev a real pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= 8'h00;
            s2_q    <= 8'h00;
            prev_q  <= 8'h00;
            state_q <= 8'h00;
        end else begin
            s1_q    <= src;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_interrupt_register.sv
// Self-checking bench for interrupt_register: directed scenarios plus a
// randomized run compared against a sample-history reference model.
module tb_interrupt_register;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic [3:0] clr;
    logic [7:0] state;

    int compared   = 0;
    int mismatched = 0;

    interrupt_register dut (
        .CLK          (clk),
        .RST          (rst),
        .North_Button (src[7]),
        .South_Button (src[6]),
        .East_Button  (src[5]),
        .West_Button  (src[4]),
        .Sw3          (src[3]),
        .Sw2          (src[2]),
        .Sw1          (src[1]),
        .Sw0          (src[0]),
        .CLR          (clr),
        .State        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remembers the input value sampled at each of the last
    // three rising edges. A source counts as rising at edge k when it was
    // sampled 1 at edge k-2 and 0 at edge k-3. Reset makes those samples 0.
    logic [7:0] hist[$] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] m_state = 8'h00;

    always @(posedge clk) begin
        logic [7:0] rising;
        logic [7:0] mask;
        if (rst) begin
            m_state = 8'h00;
            hist    = '{8'h00, 8'h00, 8'h00};
        end else begin
            rising  = hist[1] & ~hist[0];
            mask    = clr[3] ? (8'd1 << clr[2:0]) : 8'h00;
            m_state = (m_state & ~mask) | rising;
            hist.push_back(src);
            void'(hist.pop_front());
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_state(input string name, input logic [7:0] exp);
        compared++;
        if (state !== exp) begin
            mismatched++;
            $display("FAIL %s: State=%h expected=%h at %0t", name, state, exp, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src = 8'h00;
        clr = 4'h0;
        step();
        step();
        expect_state("reset", 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_state("idle", 8'h00);
        end
    endtask

    task automatic test_all_buttons();
        src = 8'hF8;
        step();
        expect_state("set_lat_k", 8'h00);
        step();
        expect_state("set_lat_k1", 8'h00);
        step();
        expect_state("set_lat_k2", 8'hF8);
        for (int i = 0; i < 20; i++) begin
            step();
            expect_state("hold_level", 8'hF8);
        end
    endtask

    task automatic test_ack();
        clr = 4'b1111;
        step();
        expect_state("ack_bit7", 8'h78);
        clr = 4'b1011;
        step();
        expect_state("ack_bit3", 8'h70);
        clr = 4'b0111;
        step();
        expect_state("ack_disabled", 8'h70);
        clr = 4'b1000;
        step();
        expect_state("ack_already_clear", 8'h70);
        clr = 4'b0000;
        step();
        expect_state("ack_idle", 8'h70);
    endtask

    task automatic test_set_beats_clear();
        src = 8'hF9;
        step();
        step();
        clr = 4'b1000;
        step();
        expect_state("set_beats_clear", 8'h71);
        step();
        expect_state("clear_after_set", 8'h70);
        clr = 4'b0000;
        step();
        expect_state("clear_idle", 8'h70);
    endtask

    task automatic test_rearm();
        src = 8'hF1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("falling_no_set", 8'h70);
        end
        clr = 4'b1011;
        step();
        expect_state("rearm_clear", 8'h70);
        clr = 4'b0000;
        src = 8'hF9;
        step();
        expect_state("rearm_k", 8'h70);
        step();
        expect_state("rearm_k1", 8'h70);
        step();
        expect_state("rearm_k2", 8'h78);
    endtask

    task automatic test_reset_mid();
        src = 8'h00;
        for (int i = 0; i < 3; i++) step();
        src = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        expect_state("all_set", 8'hFF);
        src = 8'hEF;
        for (int i = 0; i < 3; i++) step();
        expect_state("west_low", 8'hFF);
        src = 8'hFF;
        step();
        rst = 1'b1;
        src = 8'h00;
        step();
        expect_state("reset_mid", 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_state("reset_discard", 8'h00);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) src[b] = ~src[b];
            end
            clr = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 49) == 0);
            step();
            compared++;
            if (state !== m_state) begin
                mismatched++;
                $display("FAIL random[%0d]: State=%h model=%h", i, state, m_state);
            end
        end
        rst = 1'b0;
        clr = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        src = 8'h00;
        clr = 4'h0;
        test_reset();
        test_all_buttons();
        test_ack();
        test_set_beats_clear();
        test_rearm();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
